// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID fields and forwarding sources in, EX state and operands out.
// Optional counters bubble_cnt/flush_cnt exist only when ID_EX_PERF_CNT_EN is defined.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              freeze;
    logic              flush;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_rdata1;
    logic [DATA_W-1:0] id_rdata2;
    logic [DATA_W-1:0] id_imm;
    logic [3:0]        id_alu_op;
    logic              id_alu_src;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_mem_to_reg;
    logic              mem_reg_write;
    logic [REG_AW-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic              hazard_stall;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic [3:0]        ex_alu_op;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_mem_to_reg;
    logic [DATA_W-1:0] ex_opa;
    logic [DATA_W-1:0] ex_opb;
    logic [DATA_W-1:0] ex_store_data;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]       bubble_cnt;
    logic [31:0]       flush_cnt;
`endif

    modport slave (
        input  freeze, flush, id_valid, id_rs, id_rt, id_uses_rt, id_rd,
               id_rdata1, id_rdata2, id_imm, id_alu_op, id_alu_src,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               mem_reg_write, mem_rd, mem_data, wb_reg_write, wb_rd, wb_data,
        output hazard_stall, ex_valid, ex_rd, ex_alu_op, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_mem_to_reg,
`ifdef ID_EX_PERF_CNT_EN
               bubble_cnt, flush_cnt,
`endif
               ex_opa, ex_opb, ex_store_data
    );

    modport master (
        output freeze, flush, id_valid, id_rs, id_rt, id_uses_rt, id_rd,
               id_rdata1, id_rdata2, id_imm, id_alu_op, id_alu_src,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               mem_reg_write, mem_rd, mem_data, wb_reg_write, wb_rd, wb_data,
        input  hazard_stall, ex_valid, ex_rd, ex_alu_op, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_mem_to_reg,
`ifdef ID_EX_PERF_CNT_EN
               bubble_cnt, flush_cnt,
`endif
               ex_opa, ex_opb, ex_store_data
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, freeze-deferred flush and MEM/WB forwarding.
// Define ID_EX_PERF_CNT_EN to add saturating bubble/flush event counters.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    id_ex_stage_if.slave   bus
);
    logic              r_valid;
    logic [REG_AW-1:0] r_rd;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [3:0]        r_alu_op;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_to_reg;
    logic              r_alu_src;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;
    logic [DATA_W-1:0] r_imm;
    logic              r_flush_pending;

    logic w_hazard;
    logic w_kill;
    logic w_ctl_en;

    // A load in EX cannot supply its result to the instruction right behind it.
    assign w_hazard = bus.id_valid & r_valid & r_mem_read & (|r_rd) &
                      ((r_rd == bus.id_rs) | (bus.id_uses_rt & (r_rd == bus.id_rt)));
    assign w_kill   = bus.flush | r_flush_pending;
    assign w_ctl_en = bus.id_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid         <= 1'b0;
            r_rd            <= '0;
            r_rs            <= '0;
            r_rt            <= '0;
            r_alu_op        <= '0;
            r_reg_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_alu_src       <= 1'b0;
            r_rdata1        <= '0;
            r_rdata2        <= '0;
            r_imm           <= '0;
            r_flush_pending <= 1'b0;
        end else if (bus.freeze) begin
            // A flush seen while frozen must still kill the next instruction once the pipe moves.
            if (bus.flush) begin
                r_flush_pending <= 1'b1;
            end
        end else if (w_kill || w_hazard) begin
            r_valid         <= 1'b0;
            r_rd            <= '0;
            r_rs            <= '0;
            r_rt            <= '0;
            r_alu_op        <= '0;
            r_reg_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_alu_src       <= 1'b0;
            r_rdata1        <= '0;
            r_rdata2        <= '0;
            r_imm           <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            r_valid         <= bus.id_valid;
            r_rd            <= bus.id_rd;
            r_rs            <= bus.id_rs;
            r_rt            <= bus.id_rt;
            r_alu_op        <= bus.id_alu_op;
            r_reg_write     <= bus.id_reg_write  & w_ctl_en;
            r_mem_read      <= bus.id_mem_read   & w_ctl_en;
            r_mem_write     <= bus.id_mem_write  & w_ctl_en;
            r_mem_to_reg    <= bus.id_mem_to_reg & w_ctl_en;
            r_alu_src       <= bus.id_alu_src;
            r_rdata1        <= bus.id_rdata1;
            r_rdata2        <= bus.id_rdata2;
            r_imm           <= bus.id_imm;
            r_flush_pending <= 1'b0;
        end
    end

    // Path 0 forwards rs, path 1 forwards rt; the younger MEM result beats WB.
    logic [REG_AW-1:0] w_src_idx   [2];
    logic [DATA_W-1:0] w_src_rdata [2];
    logic [DATA_W-1:0] w_fwd       [2];

    assign w_src_idx[0]   = r_rs;
    assign w_src_idx[1]   = r_rt;
    assign w_src_rdata[0] = r_rdata1;
    assign w_src_rdata[1] = r_rdata2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic w_mem_hit;
            logic w_wb_hit;
            assign w_mem_hit = bus.mem_reg_write & (|bus.mem_rd) & (bus.mem_rd == w_src_idx[gi]);
            assign w_wb_hit  = bus.wb_reg_write  & (|bus.wb_rd)  & (bus.wb_rd  == w_src_idx[gi]);
            assign w_fwd[gi] = w_mem_hit ? bus.mem_data :
                               w_wb_hit  ? bus.wb_data  : w_src_rdata[gi];
        end
    endgenerate

    assign bus.hazard_stall  = w_hazard;
    assign bus.ex_valid      = r_valid;
    assign bus.ex_rd         = r_rd;
    assign bus.ex_alu_op     = r_alu_op;
    assign bus.ex_reg_write  = r_reg_write;
    assign bus.ex_mem_read   = r_mem_read;
    assign bus.ex_mem_write  = r_mem_write;
    assign bus.ex_mem_to_reg = r_mem_to_reg;
    assign bus.ex_opa        = w_fwd[0];
    assign bus.ex_opb        = r_alu_src ? r_imm : w_fwd[1];
    assign bus.ex_store_data = w_fwd[1];

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (!bus.freeze) begin
            if (w_kill && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            if (!w_kill && w_hazard && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign bus.bubble_cnt = r_bubble_cnt;
    assign bus.flush_cnt  = r_flush_cnt;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding vector table plus reset, load-use and deferred-flush sequences.
module tb_id_ex_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic        alu_src;
        logic        reg_write;
        logic        mem_we;
        logic [4:0]  mem_rd;
        logic [31:0] mem_data;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        exp_valid;
        logic        exp_rw;
        logic [31:0] exp_opa;
        logic [31:0] exp_opb;
        logic [31:0] exp_store;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                            input logic uses_rt, input logic [4:0] rd,
                            input logic [31:0] rdata1, input logic [31:0] rdata2,
                            input logic mem_read);
        bus.id_valid      = valid;
        bus.id_rs         = rs;
        bus.id_rt         = rt;
        bus.id_uses_rt    = uses_rt;
        bus.id_rd         = rd;
        bus.id_rdata1     = rdata1;
        bus.id_rdata2     = rdata2;
        bus.id_imm        = 32'h0;
        bus.id_alu_op     = 4'h2;
        bus.id_alu_src    = 1'b0;
        bus.id_reg_write  = 1'b1;
        bus.id_mem_read   = mem_read;
        bus.id_mem_write  = 1'b0;
        bus.id_mem_to_reg = mem_read;
    endtask

    task automatic fwd_off();
        bus.mem_reg_write = 1'b0;
        bus.mem_rd        = 5'd0;
        bus.mem_data      = 32'h0;
        bus.wb_reg_write  = 1'b0;
        bus.wb_rd         = 5'd0;
        bus.wb_data       = 32'h0;
    endtask

    // lw to $r followed by a dependent add: one bubble, then the add sees the MEM-forwarded load data.
    task automatic load_use(input logic [4:0] r, input logic [31:0] v);
        drive_id(1'b1, 5'd1, 5'd2, 1'b0, r, 32'h0, 32'h0, 1'b1);
        tick();
        chk("lu_lw_mem_read", {31'b0, bus.ex_mem_read}, 32'd1);
        drive_id(1'b1, r, 5'd9, 1'b1, 5'd10, 32'hDEAD, 32'h9, 1'b0);
        #1;
        chk("lu_stall", {31'b0, bus.hazard_stall}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'b0, bus.ex_valid}, 32'd0);
        chk("lu_stall_after", {31'b0, bus.hazard_stall}, 32'd0);
        tick();
        bus.mem_reg_write = 1'b1;
        bus.mem_rd        = r;
        bus.mem_data      = v;
        #1;
        chk("lu_add_valid", {31'b0, bus.ex_valid}, 32'd1);
        chk("lu_add_rd", {27'b0, bus.ex_rd}, 32'd10);
        chk("lu_add_opa", bus.ex_opa, v);
        $display("load-use r=%0d v=%h opa=%h", r, v, bus.ex_opa);
        fwd_off();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.freeze = 1'b0;
        bus.flush  = 1'b0;
        fwd_off();
        drive_id(1'b1, 5'd8, 5'd9, 1'b1, 5'd3, 32'h1111, 32'h2222, 1'b1);

        vecs[0] = '{1'b1, 5'd5, 5'd6, 5'd3, 32'h11, 32'h22, 32'h0, 1'b0, 1'b1,
                    1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB, 1'b1, 1'b1, 32'hAAAA, 32'h22, 32'h22};
        vecs[1] = '{1'b1, 5'd5, 5'd6, 5'd3, 32'h11, 32'h22, 32'h0, 1'b0, 1'b1,
                    1'b0, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB, 1'b1, 1'b1, 32'hBBBB, 32'h22, 32'h22};
        vecs[2] = '{1'b1, 5'd0, 5'd6, 5'd3, 32'h55, 32'h66, 32'h0, 1'b0, 1'b1,
                    1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB, 1'b1, 1'b1, 32'h55, 32'h66, 32'h66};
        vecs[3] = '{1'b1, 5'd2, 5'd9, 5'd4, 32'h3, 32'h7, 32'hFFFF_FFF0, 1'b1, 1'b1,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h3, 32'hFFFF_FFF0, 32'h7};
        vecs[4] = '{1'b1, 5'd1, 5'd6, 5'd4, 32'h10, 32'h66, 32'h0, 1'b0, 1'b1,
                    1'b1, 5'd7, 32'h77, 1'b1, 5'd6, 32'hCAFE, 1'b1, 1'b1, 32'h10, 32'hCAFE, 32'hCAFE};
        vecs[5] = '{1'b0, 5'd2, 5'd3, 5'd4, 32'h77, 32'h33, 32'h0, 1'b0, 1'b1,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h77, 32'h33, 32'h33};
        vecs[6] = '{1'b1, 5'd4, 5'd4, 5'd4, 32'h40, 32'h41, 32'h5, 1'b1, 1'b1,
                    1'b1, 5'd4, 32'h1, 1'b1, 5'd4, 32'h2, 1'b1, 1'b1, 32'h1, 32'h5, 32'h1};
        vecs[7] = '{1'b1, 5'd5, 5'd6, 5'd4, 32'h50, 32'h60, 32'h0, 1'b0, 1'b0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 32'hBBBB, 1'b1, 1'b0, 32'h50, 32'h60, 32'h60};

        // Reset held two cycles with a valid load presented in ID.
        tick();
        tick();
        chk("rst_ex_valid", {31'b0, bus.ex_valid}, 32'd0);
        chk("rst_ex_opa", bus.ex_opa, 32'h0);
        chk("rst_ex_opb", bus.ex_opb, 32'h0);
        chk("rst_ex_store", bus.ex_store_data, 32'h0);
        chk("rst_ex_reg_write", {31'b0, bus.ex_reg_write}, 32'd0);
        chk("rst_hazard", {31'b0, bus.hazard_stall}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
        chk("rst_bubble_cnt", bus.bubble_cnt, 32'd0);
        chk("rst_flush_cnt", bus.flush_cnt, 32'd0);
`endif
        $display("reset ex_valid=%0b opa=%h", bus.ex_valid, bus.ex_opa);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive_id(vecs[i].valid, vecs[i].rs, vecs[i].rt, 1'b1, vecs[i].rd,
                     vecs[i].rdata1, vecs[i].rdata2, 1'b0);
            bus.id_imm       = vecs[i].imm;
            bus.id_alu_src   = vecs[i].alu_src;
            bus.id_reg_write = vecs[i].reg_write;
            bus.id_alu_op    = 4'(i + 1);
            tick();
            bus.mem_reg_write = vecs[i].mem_we;
            bus.mem_rd        = vecs[i].mem_rd;
            bus.mem_data      = vecs[i].mem_data;
            bus.wb_reg_write  = vecs[i].wb_we;
            bus.wb_rd         = vecs[i].wb_rd;
            bus.wb_data       = vecs[i].wb_data;
            #1;
            chk($sformatf("v%0d_valid", i), {31'b0, bus.ex_valid}, {31'b0, vecs[i].exp_valid});
            chk($sformatf("v%0d_reg_write", i), {31'b0, bus.ex_reg_write}, {31'b0, vecs[i].exp_rw});
            chk($sformatf("v%0d_rd", i), {27'b0, bus.ex_rd}, {27'b0, vecs[i].rd});
            chk($sformatf("v%0d_alu_op", i), {28'b0, bus.ex_alu_op}, 32'(i + 1));
            chk($sformatf("v%0d_opa", i), bus.ex_opa, vecs[i].exp_opa);
            chk($sformatf("v%0d_opb", i), bus.ex_opb, vecs[i].exp_opb);
            chk($sformatf("v%0d_store", i), bus.ex_store_data, vecs[i].exp_store);
            $display("vec %0d opa=%h opb=%h store=%h", i, bus.ex_opa, bus.ex_opb, bus.ex_store_data);
            fwd_off();
        end

        load_use(5'd8, 32'h1234);
        load_use(5'd12, 32'h5678);

        // Conditions that must not stall: rt unused, $0 destination, invalid ID.
        drive_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd8, 32'h0, 32'h0, 1'b1);
        tick();
        drive_id(1'b1, 5'd3, 5'd8, 1'b0, 5'd10, 32'h0, 32'h0, 1'b0);
        #1;
        chk("hz_rt_unused", {31'b0, bus.hazard_stall}, 32'd0);
        bus.id_uses_rt = 1'b1;
        #1;
        chk("hz_rt_used", {31'b0, bus.hazard_stall}, 32'd1);
        bus.id_valid = 1'b0;
        #1;
        chk("hz_id_invalid", {31'b0, bus.hazard_stall}, 32'd0);
        tick();
        drive_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd10, 32'h0, 32'h0, 1'b0);
        #1;
        chk("hz_rd_zero", {31'b0, bus.hazard_stall}, 32'd0);
        $display("no-stall cases done");

        // Deferred flush: flush arrives while frozen and lands on the first unfrozen edge.
        drive_id(1'b1, 5'd3, 5'd4, 1'b1, 5'd11, 32'h111, 32'h0, 1'b0);
        tick();
        chk("df_pre_rd", {27'b0, bus.ex_rd}, 32'd11);
        drive_id(1'b1, 5'd3, 5'd4, 1'b1, 5'd12, 32'h222, 32'h0, 1'b0);
        bus.freeze = 1'b1;
        bus.flush  = 1'b1;
        tick();
        bus.flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("df_hold%0d_rd", k), {27'b0, bus.ex_rd}, 32'd11);
            chk($sformatf("df_hold%0d_opa", k), bus.ex_opa, 32'h111);
            if (k < 2) tick();
        end
        bus.freeze = 1'b0;
        tick();
        chk("df_bubble_valid", {31'b0, bus.ex_valid}, 32'd0);
        chk("df_bubble_rd", {27'b0, bus.ex_rd}, 32'd0);
        chk("df_bubble_rw", {31'b0, bus.ex_reg_write}, 32'd0);
        tick();
        chk("df_after_valid", {31'b0, bus.ex_valid}, 32'd1);
        chk("df_after_rd", {27'b0, bus.ex_rd}, 32'd12);
        $display("deferred flush ex_rd=%0d", bus.ex_rd);

        // Flush coinciding with a load-use hazard: stall still flagged, flush bubble taken.
        drive_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd8, 32'h0, 32'h0, 1'b1);
        tick();
        drive_id(1'b1, 5'd8, 5'd9, 1'b1, 5'd13, 32'h0, 32'h0, 1'b0);
        bus.flush = 1'b1;
        #1;
        chk("fh_stall", {31'b0, bus.hazard_stall}, 32'd1);
        tick();
        bus.flush = 1'b0;
        chk("fh_bubble_valid", {31'b0, bus.ex_valid}, 32'd0);
        tick();
        chk("fh_next_rd", {27'b0, bus.ex_rd}, 32'd13);
        $display("flush+hazard ex_rd=%0d", bus.ex_rd);

        load_use(5'd20, 32'h9ABC);

`ifdef ID_EX_PERF_CNT_EN
        chk("perf_bubble_cnt", bus.bubble_cnt, 32'd3);
        chk("perf_flush_cnt", bus.flush_cnt, 32'd2);
        $display("perf bubble_cnt=%0d flush_cnt=%0d", bus.bubble_cnt, bus.flush_cnt);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the 5-stage MIPS core; sits directly downstream of the register file and consumes its ReadData1/ReadData2 outputs plus decoded control.
- Detects load-use hazards and inserts bubbles.
- Applies branch flush, deferring it while the pipe is frozen.
- Forwards MEM/WB results onto the EX operands.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register index width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- freeze  in  1  global stall (cache busy); hold all EX state
- flush  in  1  branch taken; kill the instruction entering EX
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  source register indices
- id_uses_rt  in  1  instruction reads rt
- id_rd  in  REG_AW  destination register index
- id_rdata1, id_rdata2  in  DATA_W  register file read data
- id_imm  in  DATA_W  sign/zero-extended immediate
- id_alu_op  in  4  ALU operation
- id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
- mem_reg_write  in  1, mem_rd  in  REG_AW, mem_data  in  DATA_W  MEM-stage forwarding source
- wb_reg_write  in  1, wb_rd  in  REG_AW, wb_data  in  DATA_W  WB-stage forwarding source
- hazard_stall  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_rd  out  REG_AW, ex_alu_op  out  4, ex_reg_write / ex_mem_read / ex_mem_write / ex_mem_to_reg  out  1 each  registered control
- ex_opa, ex_opb  out  DATA_W  forwarded ALU operands (combinational from EX registers)
- ex_store_data  out  DATA_W  forwarded rt value for stores

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk.
  - On reset, all EX registers clear to 0: ex_valid, ex_rd, ex_alu_op, all control bits, stored rs/rt/rdata1/rdata2/imm/alu_src, and flush_pending.
  - Consequently ex_opa = ex_opb = ex_store_data = 0 and hazard_stall = 0.
- hazard_stall is combinational and is 1 when all of the following hold:
  - id_valid & ex_valid & ex_mem_read;
  - ex_rd != 0;
  - ex_rd == id_rs, or (id_uses_rt and ex_rd == id_rt).
- Register update priority per rising edge:
  1. reset.
  2. freeze = 1: hold all EX registers. If flush = 1, set flush_pending = 1.
  3. flush | flush_pending: load a bubble (ex_valid = 0, reg_write/mem_read/mem_write/mem_to_reg = 0; data fields are don't-care but cleared to 0). Clear flush_pending.
  4. hazard_stall: load a bubble. Upstream holds, so the same ID instruction retries next cycle.
  5. Otherwise load all id_* fields. ex_valid = id_valid. If id_valid = 0, control bits load as 0.
- Latency: 1 cycle from ID to EX outputs. A load-use hazard costs exactly 1 bubble.
- Forwarding for rs (same rule for rt into the rt path):
  - MEM wins if mem_reg_write & mem_rd != 0 & mem_rd == ex_rs.
  - Else WB if wb_reg_write & wb_rd != 0 & wb_rd == ex_rs.
  - Else the stored rdata.
  - Register 0 is never forwarded.
- Operand outputs:
  - ex_opa = forwarded rs value.
  - ex_store_data = forwarded rt value.
  - ex_opb = ex_imm if ex_alu_src = 1, else forwarded rt value.
- Forwarding operates even when ex_valid = 0 (values ignored downstream).
- Simultaneous freeze & hazard: freeze wins. hazard_stall is still driven, but upstream is frozen anyway.
- Simultaneous flush & hazard (no freeze): flush bubble. hazard_stall is still asserted that cycle.
- Reset during freeze or with flush_pending set: everything clears; the pending flush is dropped.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- When defined, adds outputs bubble_cnt (32) and flush_cnt (32), both reset to 0.
  - bubble_cnt increments on each edge where case 4 (hazard bubble) is taken.
  - flush_cnt increments on each edge where case 3 is taken.
  - Both saturate at 0xFFFFFFFF and neither increments while freeze = 1.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with id_valid = 1 -> ex_valid = 0, ex_opa = 0, ex_reg_write = 0, hazard_stall = 0.
- Load-use: EX = lw to $8 (ex_mem_read = 1); ID = add reading $8 -> hazard_stall = 1 for 1 cycle, bubble in EX. Next cycle the add enters EX; mem_rd = 8, mem_data = 0x1234 -> ex_opa = 0x1234.
- Forward priority: ex_rs = 5, mem_rd = 5 / 0xAAAA, wb_rd = 5 / 0xBBBB, both write-enabled -> ex_opa = 0xAAAA. With mem_reg_write = 0 -> 0xBBBB. With ex_rs = 0 and mem_rd = 0 -> stored rdata1.
- Deferred flush: freeze = 1 and flush = 1 in cycle N; freeze stays 1 through N+2; release at N+3 -> EX holds its prior contents through N+3. Edge N+3 loads a bubble, not the ID instruction; flush_pending = 0 afterwards.
- ALU source: id_alu_src = 1, id_imm = 0xFFFFFFF0, id_rdata2 = 7 -> ex_opb = 0xFFFFFFF0 and ex_store_data = 7.
- With ID_EX_PERF_CNT_EN: 3 load-use hazards and 2 flushes, one of them during freeze -> bubble_cnt = 3, flush_cnt = 2.
